// File: rtl/packet_buffer_reader.sv
// Read-side engine for the packet buffer RAM: turns (address, length) commands into
// RAM reads and streams the returned words out on a valid/ready port with a last marker.
module packet_buffer_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [LEN_W-1:0]    remaining_reg;
    logic                pend_reg;
    logic                pend_last_reg;
    logic                done_reg;

    // Two-entry skid FIFO holding words returned by the RAM.
    logic [DATA_W-1:0]   fifo_data_reg [2];
    logic                fifo_last_reg [2];
    logic                wr_ptr_reg;
    logic                rd_ptr_reg;
    logic [1:0]          count_reg;

    logic                cmd_fire;
    logic                push;
    logic                pop;
    logic                issue;
    logic                last_issue;
    logic [2:0]          occ_next;

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign out_valid = (count_reg != 2'd0);
    assign out_data  = fifo_data_reg[rd_ptr_reg];
    assign out_last  = out_valid && fifo_last_reg[rd_ptr_reg];
    assign pop       = out_valid && out_ready;
    assign push      = pend_reg;

    // Occupancy once this cycle's pop and the in-flight read have settled; a new read
    // is only issued if it is guaranteed a free slot when its data returns.
    assign occ_next   = {1'b0, count_reg} + {2'b00, pend_reg} - {2'b00, pop};
    assign issue      = (state_reg == READ) && (remaining_reg != '0) && (occ_next < 3'd2);
    assign last_issue = (remaining_reg == LEN_W'(1));

    assign mem_ren   = issue;
    assign mem_raddr = addr_reg;
    assign done      = done_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_reg[wr_ptr_reg] <= mem_rdata;
            fifo_last_reg[wr_ptr_reg] <= pend_last_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            pend_reg      <= 1'b0;
            pend_last_reg <= 1'b0;
            done_reg      <= 1'b0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
        end else begin
            pend_reg      <= issue;
            pend_last_reg <= last_issue;
            done_reg      <= 1'b0;

            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase

            case (state_reg)
                IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            addr_reg      <= cmd_addr;
                            remaining_reg <= cmd_len;
                            state_reg     <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_reg      <= addr_reg + ADDR_W'(1);
                        remaining_reg <= remaining_reg - LEN_W'(1);
                        if (last_issue) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_buffer_reader.sv
// Scoreboard bench for packet_buffer_reader with a behavioural 1-cycle-latency RAM.
`timescale 1ns/1ps
module tb_packet_buffer_reader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              done;
    logic              busy;

    always #5 clk = ~clk;

    packet_buffer_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .busy      (busy)
    );

    logic [DATA_W-1:0] ram [1<<ADDR_W];

    function automatic logic [DATA_W-1:0] ram_word(input int a);
        logic [31:0] t;
        t = a * 32'd40503 + 32'h1D3;
        return t[15:0] ^ 16'h5A00;
    endfunction

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= ram[mem_raddr];
    end

    int errors = 0;
    int checks = 0;
    int xfer_total = 0;
    int outstanding = 0;
    int ready_mode = 0;
    int rcyc = 0;
    int ncyc = 0;
    logic done_exp = 1'b0;
    logic stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;
    logic stall_last = 1'b0;
    logic [DATA_W:0] exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) ncyc++;

    // Downstream ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rcyc++;
            if (ready_mode == 0)      out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
            else                      out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: sample mid-cycle, compare against the scoreboard.
    always @(negedge clk) begin
        logic xfer;
        logic exp_last;
        logic [DATA_W:0] e;
        if (!rst_n) begin
            exp_q.delete();
            addr_q.delete();
            outstanding = 0;
            done_exp    = 1'b0;
            stall_prev  = 1'b0;
        end else begin
            exp_last = 1'b0;
            check_eq("done", 32'(done), 32'(done_exp));
            check_eq("occupancy_le2", 32'(outstanding <= 2), 1);
            if (stall_prev) begin
                check_eq("stall_valid", 32'(out_valid), 1);
                check_eq("stall_data", 32'(out_data), 32'(stall_data));
                check_eq("stall_last", 32'(out_last), 32'(stall_last));
            end
            if (mem_ren) begin
                check_eq("read_expected", 32'(addr_q.size() > 0), 1);
                if (addr_q.size() > 0) check_eq("raddr", 32'(mem_raddr), 32'(addr_q.pop_front()));
            end
            xfer = out_valid && out_ready;
            if (xfer) begin
                $display("xfer #%0d data=%04h last=%0b", xfer_total, out_data, out_last);
                check_eq("word_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    exp_last = e[DATA_W];
                    check_eq("out_data", 32'(out_data), 32'(e[DATA_W-1:0]));
                    check_eq("out_last", 32'(out_last), 32'(exp_last));
                end
                xfer_total++;
            end
            done_exp    = (xfer && exp_last) || (cmd_valid && cmd_ready && (cmd_len == '0));
            outstanding = outstanding + int'(mem_ren) - int'(xfer);
            stall_prev  = out_valid && !out_ready;
            stall_data  = out_data;
            stall_last  = out_last;
        end
    end

    task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n, output int hs_cyc);
        logic [ADDR_W-1:0] wa;
        cmd_addr  = a;
        cmd_len   = n;
        cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        check_eq("cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        for (int i = 0; i < int'(n); i++) begin
            wa = a + ADDR_W'(i);
            addr_q.push_back(wa);
            exp_q.push_back({(i == int'(n) - 1), ram_word(int'(wa))});
        end
        #1;
        hs_cyc    = ncyc;
        cmd_valid = 1'b0;
        $display("cmd addr=%03h len=%0d accepted at cycle %0d", a, n, hs_cyc);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && !out_valid && exp_q.size() == 0) break;
        end
        check_eq("idle_reached", 32'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, hs1, base;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = ram_word(i);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 1);
        check_eq("rst_mem_ren", 32'(mem_ren), 0);
        check_eq("rst_mem_raddr", 32'(mem_raddr), 0);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_last", 32'(out_last), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: basic len=4 with latency and back-to-back output
        send_cmd(10'h010, 11'd4, hs0);
        @(negedge clk);
        check_eq("lat_c1_mem_ren", 32'(mem_ren), 1);
        check_eq("lat_c1_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        check_eq("lat_c2_out_valid", 32'(out_valid), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("stream_valid", 32'(out_valid), 1);
        end
        @(negedge clk);
        check_eq("t1_done", 32'(done), 1);
        check_eq("t1_valid_after", 32'(out_valid), 0);
        wait_idle();

        // 2: address wrap
        send_cmd(10'h3FE, 11'd4, hs0);
        wait_idle();

        // 3: len=8 with ready toggling 1,0,0,1
        ready_mode = 1;
        send_cmd(10'h120, 11'd8, hs0);
        wait_idle();
        ready_mode = 0;

        // 4: zero-length command then back-to-back len=2
        send_cmd(10'h050, 11'd0, hs0);
        send_cmd(10'h060, 11'd2, hs1);
        check_eq("b2b_gap", 32'(hs1 - hs0), 1);
        wait_idle();

        // A few random commands under random backpressure
        ready_mode = 2;
        for (int k = 0; k < 3; k++) begin
            send_cmd(ADDR_W'($urandom_range(0, 1023)), LEN_W'($urandom_range(1, 12)), hs0);
            wait_idle();
        end
        ready_mode = 0;

        // 5: reset mid-packet
        base = xfer_total;
        send_cmd(10'h200, 11'd10, hs0);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (xfer_total >= base + 3) break;
        end
        check_eq("t5_three_words", 32'(xfer_total - base), 3);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_out_valid", 32'(out_valid), 0);
        check_eq("t5_mem_ren", 32'(mem_ren), 0);
        check_eq("t5_cmd_ready", 32'(cmd_ready), 1);
        check_eq("t5_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        base = xfer_total;
        send_cmd(10'h300, 11'd1, hs0);
        wait_idle();
        check_eq("t5_one_word", 32'(xfer_total - base), 1);

        check_eq("sb_data_left", 32'(exp_q.size()), 0);
        check_eq("sb_addr_left", 32'(addr_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
